uart_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one UART 8-bit transmitter among NUM_REQ byte-stream requesters.
- Runs on the board clock and drives the transmitter's enable, start and data inputs. Sequences one byte at a time using the transmitter's busy status, synchronised into clk_i.
- A requester keeps ownership across a multi-byte frame until it presents a byte flagged last.
- Includes a per-byte watchdog so a stuck transmitter cannot hang the bus.

---
 rtl/uart_tx_scheduler_if.sv | 14 +
 rtl/uart_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte stream bundle for the UART transmit scheduler.
// Requesters drive valid/data/last; the scheduler returns ready and the current grant.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      grant;

    modport master (output req_valid, req_data, req_last, input req_ready, grant);
    modport slave  (input req_valid, req_data, req_last, output req_ready, grant);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ requesters,
// with frame locking on the last flag and a per-byte watchdog.
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_tx_scheduler_if.slave  req,
    output logic                txen_o,
    output logic                txstart_o,
    output logic [7:0]          txin_o,
    input  logic                txbusy_i,
    output logic                timeout_o,
    output logic                active_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_LOCKED} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_busy_pipe;
    logic               w_busy_s;
    logic [IW-1:0]      r_ptr, r_owner, w_winner, w_sel, w_owner_inc;
    logic               w_any;
    logic [NUM_REQ-1:0] r_grant, w_ready;
    logic [7:0]         r_txin;
    logic               r_last, r_timeout;
    logic [WW-1:0]      r_wd;
    logic               w_wd_end, w_accept, w_fire, w_release, w_wd_run;

    assign w_busy_s = r_busy_pipe[1];

    // Scan downward so the last hit is the first valid requester at or after r_ptr.
    always_comb begin
        logic [IW-1:0] idx;
        idx      = '0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(r_ptr) + i) % NUM_REQ);
            if (req.req_valid[idx]) begin
                w_any    = 1'b1;
                w_winner = idx;
            end
        end
    end

    assign w_owner_inc = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + IW'(1);
    assign w_sel       = (r_state == S_IDLE) ? w_winner : r_owner;
    assign w_wd_end    = (r_wd == WD_LAST);
    assign w_wd_run    = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_LOCKED);

    // Progress (busy edge or owner data) is checked before the watchdog so it always wins.
    always_comb begin
        w_next    = r_state;
        w_ready   = '0;
        w_accept  = 1'b0;
        w_fire    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_ready[w_winner] = 1'b1;
                    w_accept          = 1'b1;
                    w_next            = S_START;
                end
            end
            S_START: begin
                if (w_busy_s) begin
                    w_next = S_WAIT;
                end else if (w_wd_end) begin
                    w_fire = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!w_busy_s) begin
                    w_next = S_NEXT;
                end else if (w_wd_end) begin
                    w_fire = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_NEXT: begin
                if (r_last) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (req.req_valid[r_owner]) begin
                    w_ready[r_owner] = 1'b1;
                    w_accept         = 1'b1;
                    w_next           = S_START;
                end else if (w_wd_end) begin
                    w_fire = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_busy_pipe <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_txin      <= '0;
            r_last      <= 1'b0;
            r_timeout   <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_state     <= w_next;
            r_busy_pipe <= {r_busy_pipe[0], txbusy_i};
            r_timeout   <= w_fire;
            if (w_next != r_state || !w_wd_run)
                r_wd <= '0;
            else
                r_wd <= r_wd + WW'(1);
            if (w_accept) begin
                r_txin  <= req.req_data[w_sel];
                r_last  <= req.req_last[w_sel];
                r_owner <= w_sel;
                if (r_state == S_IDLE)
                    r_grant <= w_ready;
            end
            if (w_release || w_fire) begin
                r_grant <= '0;
                r_ptr   <= w_owner_inc;
            end
        end
    end

    assign req.req_ready = w_ready;
    assign req.grant     = r_grant;
    assign txen_o        = (r_state != S_IDLE);
    assign txstart_o     = (r_state == S_START);
    assign txin_o        = r_txin;
    assign timeout_o     = r_timeout;
    assign active_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: requester byte queues, a simple transmitter busy model and
// hand-computed expected grant/byte sequences and watchdog timings.
module tb_uart_tx_scheduler;
    localparam int NR = 4;
    localparam int TO = 64;
    localparam int BUSY_LEN = 10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       txen_o, txstart_o, txbusy_i, timeout_o, active_o;
    logic [7:0] txin_o;

    always #5 clk_i = ~clk_i;

    uart_tx_scheduler_if #(.NUM_REQ(NR)) bus();

    uart_tx_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (bus),
        .txen_o    (txen_o),
        .txstart_o (txstart_o),
        .txin_o    (txin_o),
        .txbusy_i  (txbusy_i),
        .timeout_o (timeout_o),
        .active_o  (active_o)
    );

    // Requester byte queues: initial appends at wr, handshake advances rd.
    logic [7:0] sdata [NR][64];
    logic       slast [NR][64];
    int         wr [NR] = '{default: 0};
    int         rd [NR] = '{default: 0};

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            bus.req_valid[k] = (rd[k] != wr[k]);
            bus.req_data[k]  = sdata[k][rd[k] % 64];
            bus.req_last[k]  = slast[k][rd[k] % 64];
        end
    end

    always @(posedge clk_i) begin
        for (int k = 0; k < NR; k++)
            if (bus.req_valid[k] && bus.req_ready[k]) rd[k] <= rd[k] + 1;
    end

    // Transmitter model: starts on txstart when idle, busy for BUSY_LEN cycles.
    int          busy_cnt = 0;
    bit          stuck = 1'b0;
    logic [11:0] log_q [$];
    logic [11:0] exp_q [$];
    int          log_ck = 0;

    always @(posedge clk_i) begin
        if (rst_i) busy_cnt <= 0;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (txstart_o && !stuck) begin
            busy_cnt <= BUSY_LEN;
            log_q.push_back({bus.grant, txin_o});
        end
    end
    assign txbusy_i = (busy_cnt != 0);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        sdata[k][wr[k] % 64] = d;
        slast[k][wr[k] % 64] = l;
        wr[k] = wr[k] + 1;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_i);
            if (log_q.size() >= exp_q.size() && !active_o && !txbusy_i) ok = 1'b1;
        end
        if (!ok) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic v);
        int i = 0;
        while (txbusy_i !== v && i < 500) begin
            @(negedge clk_i);
            i++;
        end
        if (txbusy_i !== v) chk(tag, 32'(txbusy_i), 32'(v));
    endtask

    // From the end of a byte: 2 sync flops, WAIT->NEXT, NEXT->LOCKED.
    task automatic wait_locked(input string tag);
        wait_busy({tag, "_b1"}, 1'b1);
        wait_busy({tag, "_b0"}, 1'b0);
        tick(4);
    endtask

    task automatic check_log();
        chk("log_size", log_q.size(), exp_q.size());
        for (int i = log_ck; i < exp_q.size(); i++) begin
            if (i < log_q.size()) chk($sformatf("log[%0d]", i), 32'(log_q[i]), 32'(exp_q[i]));
            else                  chk($sformatf("log[%0d]", i), 32'hffffffff, 32'(exp_q[i]));
        end
        log_ck = exp_q.size();
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_txen"}, 32'(txen_o), 32'd0);
        chk({tag, "_txstart"}, 32'(txstart_o), 32'd0);
        chk({tag, "_txin"}, 32'(txin_o), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        chk({tag, "_active"}, 32'(active_o), 32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        int n;
        tick(3);
        rst_i = 1'b0;
        check_reset_outs("rst");

        // Single byte from requester 1
        push(1, 8'hA5, 1'b1);
        #1 chk("sb_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk_i);
        chk("sb_txstart", 32'(txstart_o), 32'd1);
        chk("sb_txen", 32'(txen_o), 32'd1);
        chk("sb_txin", 32'(txin_o), 32'hA5);
        chk("sb_grant", 32'(bus.grant), 32'h2);
        chk("sb_ready_drop", 32'(bus.req_ready), 32'd0);
        n = 0;
        while (txstart_o && n < 200) begin n++; @(negedge clk_i); end
        chk("sb_start_cycles", n, 4);
        exp_q.push_back({4'b0010, 8'hA5});
        wait_idle("sb_idle");
        chk("sb_grant_end", 32'(bus.grant), 32'd0);
        chk("sb_txen_end", 32'(txen_o), 32'd0);
        check_log();

        // Fairness from ptr=0
        rst_i = 1'b1; tick(1); rst_i = 1'b0;
        for (int k = 0; k < NR; k++) push(k, 8'h10 + 8'(k), 1'b1);
        push(0, 8'h50, 1'b1);
        #1 chk("fair_ready", 32'(bus.req_ready), 32'h1);
        exp_q.push_back({4'b0001, 8'h10});
        exp_q.push_back({4'b0010, 8'h11});
        exp_q.push_back({4'b0100, 8'h12});
        exp_q.push_back({4'b1000, 8'h13});
        exp_q.push_back({4'b0001, 8'h50});
        wait_idle("fair_idle");
        check_log();

        // Frame lock: req 2 three bytes, req 0 waiting (ptr=1)
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        push(0, 8'hAA, 1'b1);
        exp_q.push_back({4'b0100, 8'h11});
        exp_q.push_back({4'b0100, 8'h22});
        exp_q.push_back({4'b0100, 8'h33});
        exp_q.push_back({4'b0001, 8'hAA});
        wait_idle("lock_idle");
        check_log();

        // Lock stall then resume (ptr=1, req 3 alone first)
        push(3, 8'h31, 1'b0);
        wait_locked("stall");
        push(1, 8'h77, 1'b1);
        tick(20);
        chk("stall_grant", 32'(bus.grant), 32'h8);
        chk("stall_txen", 32'(txen_o), 32'd1);
        chk("stall_txstart", 32'(txstart_o), 32'd0);
        chk("stall_ready", 32'(bus.req_ready), 32'd0);
        chk("stall_timeout", 32'(timeout_o), 32'd0);
        push(3, 8'h32, 1'b1);
        #1 chk("resume_ready", 32'(bus.req_ready), 32'h8);
        exp_q.push_back({4'b1000, 8'h31});
        exp_q.push_back({4'b1000, 8'h32});
        exp_q.push_back({4'b0010, 8'h77});
        wait_idle("resume_idle");
        check_log();

        // Lock stall until watchdog (ptr=2)
        push(2, 8'h41, 1'b0);
        wait_locked("lto");
        push(3, 8'h99, 1'b1);
        n = 0;
        while (!timeout_o && n < 200) begin @(negedge clk_i); n++; end
        chk("lto_cycles", n, TO);
        chk("lto_grant", 32'(bus.grant), 32'd0);
        chk("lto_txen", 32'(txen_o), 32'd0);
        chk("lto_next_ready", 32'(bus.req_ready), 32'h8);
        @(negedge clk_i);
        chk("lto_pulse", 32'(timeout_o), 32'd0);
        chk("lto_next_grant", 32'(bus.grant), 32'h8);
        exp_q.push_back({4'b0100, 8'h41});
        exp_q.push_back({4'b1000, 8'h99});
        wait_idle("lto_idle");
        check_log();

        // Stuck transmitter (ptr=0)
        stuck = 1'b1;
        push(1, 8'hC3, 1'b1);
        @(negedge clk_i);
        n = 0;
        while (txstart_o && n < 200) begin n++; @(negedge clk_i); end
        chk("stuck_start_cycles", n, TO);
        chk("stuck_timeout", 32'(timeout_o), 32'd1);
        chk("stuck_txen", 32'(txen_o), 32'd0);
        chk("stuck_active", 32'(active_o), 32'd0);
        @(negedge clk_i);
        chk("stuck_pulse", 32'(timeout_o), 32'd0);
        check_log();
        stuck = 1'b0;

        // Reset mid-WAIT (ptr=2), then restart from ptr=0
        push(2, 8'h5A, 1'b1);
        wait_busy("rw_b1", 1'b1);
        tick(3);
        chk("rw_in_wait", 32'({txen_o, txstart_o}), 32'h2);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_reset_outs("rw");
        push(3, 8'hE1, 1'b1);
        push(1, 8'hE2, 1'b1);
        #1 chk("rw_ready", 32'(bus.req_ready), 32'h2);
        exp_q.push_back({4'b0100, 8'h5A});
        exp_q.push_back({4'b0010, 8'hE2});
        exp_q.push_back({4'b1000, 8'hE1});
        wait_idle("rw_idle");
        check_log();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
